// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// STATUS bit positions and the address-decode select type.
package dmem_mmio_responder_pkg;

  // Word offsets from the MMIO window base
  localparam int unsigned OFS_CONSOLE = 0;
  localparam int unsigned OFS_STATUS  = 1;
  localparam int unsigned OFS_CYCLES  = 2;
  localparam int unsigned OFS_HALT    = 3;

  // Bit positions inside the STATUS read word
  localparam int unsigned STAT_EMPTY  = 0;
  localparam int unsigned STAT_FULL   = 1;
  localparam int unsigned STAT_HALTED = 2;

  // Which target the current address selects
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CONSOLE,
    SEL_STATUS,
    SEL_CYCLES,
    SEL_HALT
  } sel_e;

endpackage

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// Synchronous FIFO for the console byte stream. Pop on empty is ignored;
// push on full is accepted only when a pop frees a slot in the same cycle.
// Reset clears pointers and count only; storage contents become don't-care.
module dmem_mmio_responder_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8   // power of 2, >= 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_pop,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage write; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus a small MMIO window (console FIFO,
// status, cycle counter, halt). Reads return one cycle after the address,
// read-before-write, with q_dmem updated every cycle.
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 12,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       RAM_WORDS  = 1024,
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 12'hFF0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_dmem,
  output logic              con_valid,
  output logic [DATA_W-1:0] con_data,
  input  logic              con_ready,
  output logic              con_overflow,
  output logic              halted,
  output logic [DATA_W-1:0] cycle_count
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_W-1:0] A_CONSOLE = MMIO_BASE + ADDR_W'(OFS_CONSOLE);
  localparam logic [ADDR_W-1:0] A_STATUS  = MMIO_BASE + ADDR_W'(OFS_STATUS);
  localparam logic [ADDR_W-1:0] A_CYCLES  = MMIO_BASE + ADDR_W'(OFS_CYCLES);
  localparam logic [ADDR_W-1:0] A_HALT    = MMIO_BASE + ADDR_W'(OFS_HALT);

  logic [DATA_W-1:0] r_mem [RAM_WORDS];
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_cycle;
  logic              r_halted;
  logic              r_overflow;

  sel_e              w_sel;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_head;

  assign w_ram_idx = address_dmem[RAM_AW-1:0];

  // Address decode: RAM below RAM_WORDS, four MMIO words at MMIO_BASE
  always_comb begin
    w_sel = SEL_NONE;
    if (32'(address_dmem) < RAM_WORDS) w_sel = SEL_RAM;
    else if (address_dmem == A_CONSOLE) w_sel = SEL_CONSOLE;
    else if (address_dmem == A_STATUS)  w_sel = SEL_STATUS;
    else if (address_dmem == A_CYCLES)  w_sel = SEL_CYCLES;
    else if (address_dmem == A_HALT)    w_sel = SEL_HALT;
  end

  assign w_push = wren & (w_sel == SEL_CONSOLE);
  assign w_pop  = con_valid & con_ready;

  dmem_mmio_responder_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_con_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Read mux; status reflects FIFO state before this edge's push/pop
  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      SEL_RAM:    w_rd_data = r_mem[w_ram_idx];
      SEL_STATUS: begin
        w_rd_data[STAT_EMPTY]  = w_empty;
        w_rd_data[STAT_FULL]   = w_full;
        w_rd_data[STAT_HALTED] = r_halted;
      end
      SEL_CYCLES: w_rd_data = r_cycle;
      SEL_HALT:   w_rd_data[0] = r_halted;
      default:    w_rd_data = '0;
    endcase
  end

  // Backing RAM write port; contents survive reset
  always_ff @(posedge clock) begin
    if (wren && (w_sel == SEL_RAM)) r_mem[w_ram_idx] <= data;
  end

  // Registered read data, cycle counter and sticky flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q        <= '0;
      r_cycle    <= '0;
      r_halted   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_q     <= w_rd_data;
      r_cycle <= r_cycle + DATA_W'(1);
      if (wren && (w_sel == SEL_HALT)) r_halted <= 1'b1;
      if (w_push && w_full && !w_pop)  r_overflow <= 1'b1;
    end
  end

  assign q_dmem       = r_q;
  assign con_valid    = (w_count != '0);
  assign con_data     = w_head;
  assign con_overflow = r_overflow;
  assign halted       = r_halted;
  assign cycle_count  = r_cycle;

endmodule
